// File: rtl/spectral_band_permuter.sv
// Ping-pong spectrum buffer with optional bit-reverse unscramble and
// key-driven band permutation (scramble or inverse) toward the IFFT.
module spectral_band_permuter #(
  parameter int LOG2N     = 7,
  parameter int DW        = 16,
  parameter int LOG2B     = 3,
  parameter int BITREV_IN = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          di_en,
  input  logic [DW-1:0]                 di_re,
  input  logic [DW-1:0]                 di_im,
  input  logic [(2**LOG2B)*LOG2B-1:0]   perm_key,
  input  logic                          descramble,
  output logic                          do_en,
  output logic [LOG2N-1:0]              do_count,
  output logic [DW-1:0]                 do_re,
  output logic [DW-1:0]                 do_im,
  output logic                          key_err
);

  localparam int N  = 2**LOG2N;
  localparam int NB = 2**LOG2B;
  localparam int KW = NB*LOG2B;
  localparam int OW = LOG2N-LOG2B;

  typedef enum logic {IDLE, RUN} st_t;

  function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  logic [2*DW-1:0]        mem_q [2*N];
  logic [2*DW-1:0]        ram_q;

  logic [LOG2N-1:0]       wr_cnt_q;
  logic                   wr_bank_q;
  logic [1:0]             full_q, full_d;
  logic [1:0]             full_set, full_clr;
  logic [1:0][KW-1:0]     key_q;
  logic [1:0]             desc_q;
  logic                   wr_last;
  logic [LOG2N-1:0]       wr_addr;

  st_t                    state_q, state_d;
  logic [LOG2N-1:0]       rd_cnt_q, rd_cnt_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   rd_go, rd_done;

  logic [LOG2B-1:0]       fld [NB];
  logic [LOG2B-1:0]       band, fwd, inv, sel;
  logic [OW-1:0]          offs;
  logic                   key_ok;
  logic [LOG2N-1:0]       src;

  logic                   v1_q, err1_q;
  logic [LOG2N-1:0]       cnt1_q;
  logic                   do_en_q, key_err_q;
  logic [LOG2N-1:0]       do_count_q;
  logic [DW-1:0]          do_re_q, do_im_q;

  assign wr_last  = di_en && (wr_cnt_q == LOG2N'(N-1));
  assign wr_addr  = (BITREV_IN != 0) ? rev(wr_cnt_q) : wr_cnt_q;
  assign full_set = wr_last ? (2'b01 << wr_bank_q) : 2'b00;
  assign full_clr = rd_done ? (2'b01 << rd_bank_q) : 2'b00;
  assign full_d   = (full_q | full_set) & ~full_clr;

  // A bank filling in the same cycle keeps the read burst seamless.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_go     = 1'b0;
    rd_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_go    = 1'b1;
          rd_cnt_d = rd_cnt_q + LOG2N'(1);
          state_d  = RUN;
        end
      end
      RUN: begin
        rd_go    = 1'b1;
        rd_cnt_d = rd_cnt_q + LOG2N'(1);
        if (rd_cnt_q == LOG2N'(N-1)) begin
          rd_done   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          if (full_q[~rd_bank_q] || full_set[~rd_bank_q])
            state_d = RUN;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NB; i++)
      fld[i] = key_q[rd_bank_q][i*LOG2B +: LOG2B];
    key_ok = 1'b1;
    for (int i = 0; i < NB; i++)
      for (int j = i + 1; j < NB; j++)
        if (fld[i] == fld[j]) key_ok = 1'b0;
    band = rd_cnt_q[LOG2N-1 -: LOG2B];
    offs = rd_cnt_q[OW-1:0];
    fwd  = fld[band];
    inv  = '0;
    for (int j = 0; j < NB; j++)
      if (fld[j] == band) inv = LOG2B'(j);
    sel  = desc_q[rd_bank_q] ? inv : fwd;
    src  = key_ok ? {sel, offs} : rd_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (di_en) mem_q[{wr_bank_q, wr_addr}] <= {di_re, di_im};
    if (rd_go) ram_q <= mem_q[{rd_bank_q, src}];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      key_q      <= '0;
      desc_q     <= '0;
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      v1_q       <= 1'b0;
      err1_q     <= 1'b0;
      cnt1_q     <= '0;
      do_en_q    <= 1'b0;
      key_err_q  <= 1'b0;
      do_count_q <= '0;
      do_re_q    <= '0;
      do_im_q    <= '0;
    end else begin
      if (di_en) wr_cnt_q <= wr_cnt_q + LOG2N'(1);
      if (wr_last) begin
        wr_bank_q         <= ~wr_bank_q;
        key_q[wr_bank_q]  <= perm_key;
        desc_q[wr_bank_q] <= descramble;
      end
      full_q    <= full_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      v1_q      <= rd_go;
      err1_q    <= rd_go & ~key_ok;
      cnt1_q    <= rd_cnt_q;
      do_en_q   <= v1_q;
      key_err_q <= v1_q & err1_q;
      if (v1_q) begin
        do_count_q <= cnt1_q;
        do_re_q    <= ram_q[2*DW-1:DW];
        do_im_q    <= ram_q[DW-1:0];
      end
    end
  end

  assign do_en    = do_en_q;
  assign do_count = do_count_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;
  assign key_err  = key_err_q;

endmodule

// File: tb/tb_spectral_band_permuter.sv
// Directed bench: natural-order and bit-reversed instances fed in parallel.
module tb_spectral_band_permuter;
  localparam int N  = 128;
  localparam int DW = 16;
  localparam int KW = 24;
  localparam logic [KW-1:0] K_ID  = 24'hFAC688;
  localparam logic [KW-1:0] K_REV = 24'h053977;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic di_en = 1'b0;
  logic [DW-1:0] di_re = '0, di_im = '0;
  logic [KW-1:0] perm_key = '0;
  logic descramble = 1'b0;

  logic en0, err0, en1, err1;
  logic [6:0] cnt0, cnt1;
  logic [DW-1:0] re0, im0, re1, im1;

  spectral_band_permuter #(.BITREV_IN(0)) u0 (
    .clock(clock), .reset(reset), .di_en(di_en),
    .di_re(di_re), .di_im(di_im), .perm_key(perm_key),
    .descramble(descramble), .do_en(en0), .do_count(cnt0),
    .do_re(re0), .do_im(im0), .key_err(err0));

  spectral_band_permuter #(.BITREV_IN(1)) u1 (
    .clock(clock), .reset(reset), .di_en(di_en),
    .di_re(di_re), .di_im(di_im), .perm_key(perm_key),
    .descramble(descramble), .do_en(en1), .do_count(cnt1),
    .do_re(re1), .do_im(im1), .key_err(err1));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] st_re [N];
  logic [DW-1:0] st_im [N];
  logic [DW-1:0] org_re [N];
  logic [DW-1:0] org_im [N];
  logic [DW-1:0] cap_re [1024];
  logic [DW-1:0] cap_im [1024];
  logic [6:0]    cap_cnt [1024];
  logic          cap_err [1024];
  int cap_n, first_cyc, drv_start, nbursts;
  int bursts [16];

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = x[6-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int nsamp, input logic [KW-1:0] key,
                       input logic dsc, input bit gaps, input bit mark);
    for (int i = 0; i < nsamp; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clock);
          di_en = 1'b0;
        end
      @(negedge clock);
      if (mark && i == 0) drv_start = cyc;
      di_en = 1'b1;
      di_re = st_re[i];
      di_im = st_im[i];
      perm_key = key;
      descramble = dsc;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    di_en = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic collect(input int nexp, input bit which, input int budget);
    int waited = 0;
    int run = 0;
    logic e;
    cap_n = 0;
    nbursts = 0;
    first_cyc = -1;
    while (cap_n < nexp && waited < budget) begin
      @(negedge clock);
      waited++;
      e = which ? en1 : en0;
      if (e) begin
        if (first_cyc < 0) first_cyc = cyc;
        cap_re[cap_n]  = which ? re1 : re0;
        cap_im[cap_n]  = which ? im1 : im0;
        cap_cnt[cap_n] = which ? cnt1 : cnt0;
        cap_err[cap_n] = which ? err1 : err0;
        cap_n++;
        run++;
      end else if (run > 0) begin
        if (nbursts < 16) bursts[nbursts] = run;
        nbursts++;
        run = 0;
      end
    end
    if (run > 0) begin
      if (nbursts < 16) bursts[nbursts] = run;
      nbursts++;
    end
    chk("samples_in_budget", 64'(cap_n), 64'(nexp));
  endtask

  task automatic frame0(input logic [KW-1:0] key, input logic dsc);
    fork
      begin drive(N, key, dsc, 1'b0, 1'b1); idle(2); end
      collect(N, 1'b0, 400);
    join
  endtask

  initial begin
    logic [KW-1:0] rkey;
    int perm [8];
    int t, kk;

    repeat (3) @(negedge clock);
    chk("rst_do_en", 64'(en0), 64'd0);
    chk("rst_do_count", 64'(cnt0), 64'd0);
    chk("rst_do_re", 64'(re0), 64'd0);
    chk("rst_do_im", 64'(im0), 64'd0);
    chk("rst_key_err", 64'(err0), 64'd0);
    chk("rst_u1", {re1, im1, cnt1, en1, err1}, 64'd0);
    reset = 1'b1;
    idle(3);

    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(n);
      st_im[n] = DW'(-n);
    end
    frame0(K_ID, 1'b0);
    chk("id_latency", 64'(first_cyc - drv_start), 64'd130);
    for (int k = 0; k < N; k++)
      chk($sformatf("id[%0d]", k),
          {cap_cnt[k], cap_re[k], cap_im[k], cap_err[k]},
          {7'(k), 16'(k), 16'(-k), 1'b0});
    idle(5);

    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(n);
      st_im[n] = DW'(n + 300);
    end
    frame0(K_REV, 1'b0);
    for (int k = 0; k < N; k++) begin
      kk = (7 - k / 16) * 16 + k % 16;
      chk($sformatf("brev[%0d]", k),
          {cap_cnt[k], cap_re[k], cap_im[k], cap_err[k]},
          {7'(k), 16'(kk), 16'(kk + 300), 1'b0});
    end
    idle(5);

    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      kk = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[kk];
      perm[kk] = t;
    end
    rkey = '0;
    for (int i = 0; i < 8; i++) rkey[i*3 +: 3] = 3'(perm[i]);
    for (int n = 0; n < N; n++) begin
      org_re[n] = DW'($urandom);
      org_im[n] = DW'($urandom);
      st_re[n] = org_re[n];
      st_im[n] = org_im[n];
    end
    frame0(rkey, 1'b0);
    chk("scr_err", 64'(cap_err[0]), 64'd0);
    for (int n = 0; n < N; n++) begin
      st_re[n] = cap_re[n];
      st_im[n] = cap_im[n];
    end
    idle(5);
    frame0(rkey, 1'b1);
    for (int k = 0; k < N; k++)
      chk($sformatf("rt[%0d]", k),
          {cap_re[k], cap_im[k], cap_err[k]},
          {org_re[k], org_im[k], 1'b0});
    idle(5);

    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(n);
      st_im[n] = DW'(n ^ 77);
    end
    frame0(24'h000000, 1'b0);
    for (int k = 0; k < N; k++)
      chk($sformatf("bad[%0d]", k),
          {cap_re[k], cap_im[k], cap_err[k]},
          {16'(k), 16'(k ^ 77), 1'b1});
    idle(5);
    frame0(K_ID, 1'b0);
    for (int k = 0; k < N; k += 32)
      chk($sformatf("good_after_bad[%0d]", k),
          {cap_re[k], cap_err[k]}, {16'(k), 1'b0});
    idle(5);

    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(rev7(7'(n)));
      st_im[n] = DW'(rev7(7'(n))) + 16'd1000;
    end
    fork
      begin
        repeat (4) drive(N, K_ID, 1'b0, 1'b0, 1'b0);
        idle(2);
      end
      collect(4 * N, 1'b1, 900);
    join
    chk("b2b_bursts", 64'(nbursts), 64'd1);
    chk("b2b_len", 64'(bursts[0]), 64'd512);
    for (int k = 0; k < 4 * N; k++)
      chk($sformatf("b2b[%0d]", k), {cap_re[k], cap_im[k]},
          {16'(k % N), 16'(k % N + 1000)});
    idle(5);

    fork
      begin
        repeat (4) drive(N, K_ID, 1'b0, 1'b1, 1'b0);
        idle(2);
      end
      collect(4 * N, 1'b1, 3000);
    join
    chk("gap_bursts", 64'(nbursts), 64'd4);
    for (int f = 0; f < 4; f++)
      chk($sformatf("gap_len%0d", f), 64'(bursts[f]), 64'd128);
    for (int k = 0; k < 4 * N; k++)
      chk($sformatf("gap[%0d]", k), 64'(cap_re[k]), 64'(k % N));
    idle(5);

    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(n);
      st_im[n] = DW'(n);
    end
    drive(N, K_ID, 1'b0, 1'b0, 1'b0);
    drive(60, K_ID, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk("busy_before_rst", 64'(en0), 64'd1);
    #1;
    di_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_async_en0", 64'(en0), 64'd0);
    chk("rst_async_en1", 64'(en1), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < N; n++) begin
      st_re[n] = DW'(n) ^ 16'h5A5A;
      st_im[n] = DW'(n + 7);
    end
    frame0(K_ID, 1'b0);
    chk("post_rst_latency", 64'(first_cyc - drv_start), 64'd130);
    for (int k = 0; k < N; k++)
      chk($sformatf("post_rst[%0d]", k),
          {cap_cnt[k], cap_re[k], cap_im[k]},
          {7'(k), 16'(k) ^ 16'h5A5A, 16'(k + 7)});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
